// File: rtl/cond_incr_executor.sv
// Conditional-increment executor: accepts one encoded op per handshake, reads its operands
// from an internal register file one per cycle, compares, optionally sets a flag, and increments.
module cond_incr_executor #(
    parameter int NREGS  = 16,
    parameter int AW     = $clog2(NREGS),
    parameter int NFLAGS = 8,
    parameter int FW     = $clog2(NFLAGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_target,
    input  logic [2:0]        in_cmp_op,
    input  logic              in_cmp_is_addr,
    input  logic [31:0]       in_cmp_val,
    input  logic              in_inc_is_addr,
    input  logic [31:0]       in_inc_val,
    input  logic [FW-1:0]     in_set_flag,
    input  logic [FW-1:0]     in_cond_flag,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [NFLAGS-1:0] flags,
    output logic              done_valid,
    output logic              done_taken,
    output logic [31:0]       done_result
);

    typedef enum logic [2:0] {IDLE, RD_TGT, RD_CMP, RD_INC, EXEC, WB} state_t;

    state_t state_q, state_d;

    logic [31:0]       regs_q [NREGS];
    logic [NFLAGS-1:0] flags_q;

    logic [AW-1:0] target_q;
    logic [2:0]    cmpOp_q;
    logic          cmpIsAddr_q, incIsAddr_q;
    logic [31:0]   cmpVal_q, incVal_q;
    logic [FW-1:0] setSel_q, condSel_q;
    logic [31:0]   a_q, b_q, c_q;
    logic          cond_q, res_q;

    logic          accept;
    logic [AW-1:0] readAddr;
    logic [31:0]   readData;
    logic [NFLAGS-1:0] flagsShifted;
    logic          condNow;
    logic          cmpResult;
    logic [31:0]   sum;
    logic          taken;

    function automatic logic compare(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd2:    return x < y;
            3'd3:    return x <= y;
            3'd4:    return x > y;
            3'd5:    return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RD_TGT;
            RD_TGT:  state_d = RD_CMP;
            RD_CMP:  state_d = RD_INC;
            RD_INC:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = accept ? RD_TGT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE) || (state_q == WB);
        done_valid  = (state_q == WB);
        done_taken  = (state_q == WB) && taken;
        done_result = (state_q == WB) ? (taken ? sum : a_q) : 32'd0;
    end

    assign accept = in_valid && in_ready;

    // Single read port shared by the three operand-read states.
    always_comb begin
        readAddr = target_q;
        case (state_q)
            RD_CMP:  readAddr = cmpVal_q[AW-1:0];
            RD_INC:  readAddr = incVal_q[AW-1:0];
            default: readAddr = target_q;
        endcase
    end

    assign readData     = regs_q[readAddr];
    assign flagsShifted = flags_q >> condSel_q;
    assign condNow      = (condSel_q >= FW'(NFLAGS)) || flagsShifted[0];
    assign cmpResult    = compare(cmpOp_q, a_q, b_q);
    assign sum          = a_q + c_q;
    assign taken        = cond_q && res_q;
    assign dbg_data     = regs_q[dbg_addr];
    assign flags        = flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q    <= '0;
            cmpOp_q     <= '0;
            cmpIsAddr_q <= 1'b0;
            cmpVal_q    <= '0;
            incIsAddr_q <= 1'b0;
            incVal_q    <= '0;
            setSel_q    <= '0;
            condSel_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            cond_q      <= 1'b0;
            res_q       <= 1'b0;
            flags_q     <= '0;
        end else begin
            if (accept) begin
                target_q    <= in_target;
                cmpOp_q     <= in_cmp_op;
                cmpIsAddr_q <= in_cmp_is_addr;
                cmpVal_q    <= in_cmp_val;
                incIsAddr_q <= in_inc_is_addr;
                incVal_q    <= in_inc_val;
                setSel_q    <= in_set_flag;
                condSel_q   <= in_cond_flag;
            end
            case (state_q)
                RD_TGT: a_q <= readData;
                RD_CMP: b_q <= cmpIsAddr_q ? readData : cmpVal_q;
                RD_INC: c_q <= incIsAddr_q ? readData : incVal_q;
                EXEC: begin
                    cond_q <= condNow;
                    res_q  <= cmpResult;
                    if (condNow) begin
                        for (int i = 0; i < NFLAGS; i++) begin
                            if (setSel_q == FW'(i)) flags_q[i] <= cmpResult;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Preload only lands while idle-ready; a completing writeback to the same register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (ld_en && in_ready) regs_q[ld_addr] <= ld_data;
            if (state_q == WB && taken) regs_q[target_q] <= sum;
        end
    end

endmodule

// File: tb/tb_cond_incr_executor.sv
// Self-checking bench for cond_incr_executor: directed scenarios plus randomized ops
// compared against an array-based behavioural model.
module tb_cond_incr_executor;

    localparam int NREGS  = 16;
    localparam int AW     = 4;
    localparam int NFLAGS = 8;
    localparam int FW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_target;
    logic [2:0]        in_cmp_op;
    logic              in_cmp_is_addr;
    logic [31:0]       in_cmp_val;
    logic              in_inc_is_addr;
    logic [31:0]       in_inc_val;
    logic [FW-1:0]     in_set_flag;
    logic [FW-1:0]     in_cond_flag;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [31:0]       ld_data;
    logic [AW-1:0]     dbg_addr;
    logic [31:0]       dbg_data;
    logic [NFLAGS-1:0] flags;
    logic              done_valid;
    logic              done_taken;
    logic [31:0]       done_result;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0]       refRegs [NREGS];
    logic [NFLAGS-1:0] refFlags;

    cond_incr_executor dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_target(in_target), .in_cmp_op(in_cmp_op),
        .in_cmp_is_addr(in_cmp_is_addr), .in_cmp_val(in_cmp_val),
        .in_inc_is_addr(in_inc_is_addr), .in_inc_val(in_inc_val),
        .in_set_flag(in_set_flag), .in_cond_flag(in_cond_flag),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flags(flags),
        .done_valid(done_valid), .done_taken(done_taken), .done_result(done_result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < NREGS; i++) refRegs[i] = 32'd0;
        refFlags = '0;
    endtask

    // Called at a negedge while idle; the load lands on the next posedge.
    task automatic preloadReg(input logic [AW-1:0] addr, input logic [31:0] data);
        ld_en = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        refRegs[addr] = data;
        @(negedge clk);
    endtask

    task automatic checkRegs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            checkOutput($sformatf("%s_reg%0d", tag, i), dbg_data, refRegs[i]);
        end
    endtask

    // Issues one op from a negedge, predicts it, and returns at the negedge of its done cycle.
    task automatic applyStimulus(input logic [AW-1:0] tgt, input logic [2:0] op,
                                 input logic cmpIsAddr, input logic [31:0] cmpVal,
                                 input logic incIsAddr, input logic [31:0] incVal,
                                 input logic [FW-1:0] setSel, input logic [FW-1:0] condSel,
                                 input logic withLoad, input logic [AW-1:0] ldA,
                                 input logic [31:0] ldD);
        logic [31:0] a, b, c, expResult;
        logic cond, r, expTaken;
        int waitCnt, lat;
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("ready_before_issue", 32'(in_ready), 32'd1);
        in_valid       = 1'b1;
        in_target      = tgt;
        in_cmp_op      = op;
        in_cmp_is_addr = cmpIsAddr;
        in_cmp_val     = cmpVal;
        in_inc_is_addr = incIsAddr;
        in_inc_val     = incVal;
        in_set_flag    = setSel;
        in_cond_flag   = condSel;
        if (withLoad) begin
            ld_en = 1'b1;
            ld_addr = ldA;
            ld_data = ldD;
            refRegs[ldA] = ldD;
        end
        a = refRegs[tgt];
        b = cmpIsAddr ? refRegs[cmpVal[AW-1:0]] : cmpVal;
        c = incIsAddr ? refRegs[incVal[AW-1:0]] : incVal;
        cond = (condSel >= FW'(NFLAGS)) || refFlags[condSel[2:0]];
        case (op)
            3'd0: r = (a == b);
            3'd1: r = (a != b);
            3'd2: r = (a < b);
            3'd3: r = (a <= b);
            3'd4: r = (a > b);
            3'd5: r = (a >= b);
            default: r = 1'b0;
        endcase
        if (cond && setSel < FW'(NFLAGS)) refFlags[setSel[2:0]] = r;
        expTaken = cond && r;
        expResult = expTaken ? a + c : a;
        if (expTaken) refRegs[tgt] = expResult;

        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_cmp_val = $urandom;
        in_inc_val = $urandom;
        in_target = AW'($urandom);
        ld_en = 1'b0;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (done_valid) break;
        end
        checkOutput("done_latency", 32'(lat), 32'd5);
        if (done_valid) begin
            checkOutput("done_taken", 32'(done_taken), 32'(expTaken));
            checkOutput("done_result", done_result, expResult);
            checkOutput("ready_on_done", 32'(in_ready), 32'd1);
        end
        checkOutput("flags", 32'(flags), 32'(refFlags));
    endtask

    task automatic idleCheck();
        @(negedge clk);
        checkOutput("done_pulse_width", 32'(done_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic sawDone;
        rst = 1'b1;
        in_valid = 1'b0;
        in_target = '0;
        in_cmp_op = '0;
        in_cmp_is_addr = 1'b0;
        in_cmp_val = '0;
        in_inc_is_addr = 1'b0;
        in_inc_val = '0;
        in_set_flag = '0;
        in_cond_flag = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        dbg_addr = '0;
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_done", 32'(done_valid), 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkRegs("reset");

        // LT taken, flag set, increment by immediate.
        preloadReg(4'd3, 32'd5);
        applyStimulus(4'd3, 3'd2, 1'b0, 32'd10, 1'b0, 32'd1, 4'd2, 4'd8, 1'b0, 4'd0, 32'd0);
        checkOutput("lt_taken_result", done_result, 32'd6);
        checkOutput("lt_taken_flag2", 32'(flags[2]), 32'd1);
        idleCheck();

        // LT not taken clears the flag and leaves the register alone.
        preloadReg(4'd3, 32'd10);
        applyStimulus(4'd3, 3'd2, 1'b0, 32'd10, 1'b0, 32'd1, 4'd2, 4'd8, 1'b0, 4'd0, 32'd0);
        checkOutput("lt_not_taken", 32'(done_taken), 32'd0);
        checkOutput("lt_not_taken_flag2", 32'(flags[2]), 32'd0);
        idleCheck();
        checkRegs("lt_not_taken");

        // 32-bit wrap.
        preloadReg(4'd4, 32'hFFFF_FFFF);
        applyStimulus(4'd4, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'd2, 4'd8, 4'd8, 1'b0, 4'd0, 32'd0);
        checkOutput("wrap_result", done_result, 32'd1);
        idleCheck();

        // Condition flag 1 clear: nothing happens, not even the flag write.
        applyStimulus(4'd6, 3'd0, 1'b0, 32'd0, 1'b0, 32'd3, 4'd1, 4'd1, 1'b0, 4'd0, 32'd0);
        checkOutput("cond_blocked_taken", 32'(done_taken), 32'd0);
        idleCheck();
        applyStimulus(4'd7, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd1, 4'd8, 1'b0, 4'd0, 32'd0);
        checkOutput("set_flag1", 32'(flags[1]), 32'd1);
        applyStimulus(4'd6, 3'd0, 1'b0, 32'd0, 1'b0, 32'd3, 4'd1, 4'd1, 1'b0, 4'd0, 32'd0);
        checkOutput("cond_pass_taken", 32'(done_taken), 32'd1);
        idleCheck();

        // Aliased registers, then a back-to-back op accepted on the done cycle.
        preloadReg(4'd5, 32'd7);
        applyStimulus(4'd5, 3'd5, 1'b1, 32'd5, 1'b1, 32'd5, 4'd8, 4'd8, 1'b0, 4'd0, 32'd0);
        checkOutput("alias_result", done_result, 32'd14);
        applyStimulus(4'd5, 3'd4, 1'b0, 32'd13, 1'b1, 32'd5, 4'd0, 4'd8, 1'b0, 4'd0, 32'd0);
        checkOutput("b2b_result", done_result, 32'd28);
        idleCheck();

        // Load in the acceptance cycle is seen by the op's reads.
        applyStimulus(4'd9, 3'd0, 1'b0, 32'd42, 1'b0, 32'd8, 4'd3, 4'd8, 1'b1, 4'd9, 32'd42);
        checkOutput("ld_same_cycle_result", done_result, 32'd50);
        idleCheck();
        checkRegs("directed");

        // Reset while in RD_INC drops the op.
        in_valid = 1'b1;
        in_target = 4'd2;
        in_cmp_op = 3'd0;
        in_cmp_is_addr = 1'b0;
        in_cmp_val = 32'd0;
        in_inc_is_addr = 1'b0;
        in_inc_val = 32'd1;
        in_set_flag = 4'd0;
        in_cond_flag = 4'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        resetModel();
        checkOutput("midop_reset_ready", 32'(in_ready), 32'd1);
        checkOutput("midop_reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (lat = 0; lat < 6; lat++) begin
            @(negedge clk);
            if (done_valid) sawDone = 1'b1;
        end
        checkOutput("midop_reset_no_done", 32'(sawDone), 32'd0);
        checkOutput("midop_reset_ready_after", 32'(in_ready), 32'd1);
        checkRegs("midop_reset");

        // Randomized ops against the model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] cv, iv;
            cv = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            iv = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                preloadReg(AW'($urandom), 32'($urandom_range(0, 20)));
            applyStimulus(AW'($urandom), 3'($urandom_range(0, 7)),
                          1'($urandom), cv, 1'($urandom), iv,
                          FW'($urandom_range(0, 9)), FW'($urandom_range(0, 11)),
                          ($urandom_range(0, 4) == 0), AW'($urandom), 32'($urandom_range(0, 20)));
            if ($urandom_range(0, 1) == 0) idleCheck();
        end
        idleCheck();
        checkRegs("random_final");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
